// File: rtl/pads_rst_ctrl_pkg.sv
// pads_rst_ctrl_pkg: shared FSM states, reset cause codes and delay range check for the pad-ring reset sequencer
package pads_rst_ctrl_pkg;
  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_IO_WAIT   = 3'd1,
    S_CORE_WAIT = 3'd2,
    S_RUN       = 3'd3,
    S_SW_RST    = 3'd4
  } state_t;
  localparam logic [1:0] RST_CAUSE_POR = 2'b01;
  localparam logic [1:0] RST_CAUSE_SW  = 2'b10;
  function automatic bit dly_ok(input int v, input int w);
    return v >= 1 && v < (1 << w);
  endfunction
endpackage

// File: rtl/pads_rst_ctrl_rst_sync.sv
// rst_sync: async-assert/sync-deassert reset synchronizer (clk, rst_n in; rst_sync_n out)
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);
  (* dont_touch = "true" *) logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[SYNC_STAGES-2:0], 1'b1};
  assign rst_sync_n = ff[SYNC_STAGES-1];
endmodule

// File: rtl/pads_rst_ctrl.sv
// pads_rst_ctrl: ordered pad-ring reset release (io_oe_en/periph_rst_n, then core_rst_n/ready) plus software warm reset
module pads_rst_ctrl
  import pads_rst_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IO_DLY      = 16,
  parameter int CORE_DLY    = 32,
  parameter int SW_RST_LEN  = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  output logic       rst_sync_n,
  output logic       io_oe_en,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       ready,
  output logic [1:0] rst_cause
);
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("SYNC_STAGES must be >= 2");
  end
  if (!dly_ok(IO_DLY, CNT_W)) begin : g_io_chk
    $error("IO_DLY out of range for CNT_W");
  end
  if (!dly_ok(CORE_DLY, CNT_W)) begin : g_core_chk
    $error("CORE_DLY out of range for CNT_W");
  end
  if (!dly_ok(SW_RST_LEN, CNT_W)) begin : g_sw_chk
    $error("SW_RST_LEN out of range for CNT_W");
  end
  localparam logic [CNT_W-1:0] IO_LAST   = CNT_W'(IO_DLY - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DLY - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_LEN - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic io_d, periph_d, core_d, ready_d;
  logic [1:0] cause_d;
  logic req_r, req_q;
  logic sw_edge;
  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );
  assign sw_edge = req_r & ~req_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_HOLD;
      cnt          <= '0;
      io_oe_en     <= 1'b0;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      ready        <= 1'b0;
      rst_cause    <= RST_CAUSE_POR;
      req_r        <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      io_oe_en     <= io_d;
      periph_rst_n <= periph_d;
      core_rst_n   <= core_d;
      ready        <= ready_d;
      rst_cause    <= cause_d;
      req_r        <= sw_rst_req;
      req_q        <= req_r;
    end
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    io_d     = io_oe_en;
    periph_d = periph_rst_n;
    core_d   = core_rst_n;
    ready_d  = ready;
    cause_d  = rst_cause;
    case (state)
      S_HOLD: begin
        cnt_d   = '0;
        state_d = rst_sync_n ? S_IO_WAIT : S_HOLD;
      end
      S_IO_WAIT:
        if (cnt == IO_LAST) begin
          io_d     = 1'b1;
          periph_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_CORE_WAIT;
        end else cnt_d = cnt + 1'b1;
      S_CORE_WAIT:
        if (cnt == CORE_LAST) begin
          core_d  = 1'b1;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end else cnt_d = cnt + 1'b1;
      S_RUN:
        if (sw_edge) begin
          core_d  = 1'b0;
          ready_d = 1'b0;
          cause_d = RST_CAUSE_SW;
          cnt_d   = '0;
          state_d = S_SW_RST;
        end
      S_SW_RST:
        if (cnt == SW_LAST) begin
          core_d  = 1'b1;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end else cnt_d = cnt + 1'b1;
      default: begin
        state_d  = S_HOLD;
        cnt_d    = '0;
        io_d     = 1'b0;
        periph_d = 1'b0;
        core_d   = 1'b0;
        ready_d  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_pads_rst_ctrl.sv
// tb_pads_rst_ctrl: randomized self-checking bench for pads_rst_ctrl against an edge-count reference model
module tb_pads_rst_ctrl;
  localparam int SYNC = 2, IO = 16, CORE = 32, SWL = 8;
  logic clk = 1'b0;
  logic rst_n, sw_rst_req;
  logic rst_sync_n, io_oe_en, periph_rst_n, core_rst_n, ready;
  logic [1:0] rst_cause;
  int compared = 0, mismatched = 0;
  pads_rst_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_rst_req   (sw_rst_req),
    .rst_sync_n   (rst_sync_n),
    .io_oe_en     (io_oe_en),
    .periph_rst_n (periph_rst_n),
    .core_rst_n   (core_rst_n),
    .ready        (ready),
    .rst_cause    (rst_cause)
  );
  always #5 clk = ~clk;
  wire [6:0] obs = {rst_sync_n, io_oe_en, periph_rst_n, core_rst_n, ready, rst_cause};
  int n, sw_left, m_cause;
  bit h1, h2, m_core, m_ready;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n = 0; sw_left = 0; m_cause = 1; h1 = 0; h2 = 0; m_core = 0; m_ready = 0;
    end else begin
      n++;
      if (sw_left > 0) sw_left--;
      else if (m_ready && h1 && !h2) begin
        sw_left = SWL;
        m_cause = 2;
      end
      m_core = (n >= SYNC + IO + CORE + 1) && sw_left == 0;
      m_ready = m_core;
      h2 = h1;
      h1 = sw_rst_req;
    end
  function automatic logic [6:0] exp_vec();
    logic io;
    io = n >= SYNC + IO + 1;
    return {n >= SYNC, io, io, m_core, m_ready, 2'(m_cause)};
  endfunction
  task automatic test_reset();
    int io_at, core_at;
    io_at = -1; core_at = -1;
    rst_n = 1'b0; sw_rst_req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      compared++;
      if (obs !== 7'b0000001) begin mismatched++; $display("FAIL reset_hold got %b want 0000001", obs); end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 55; e++) begin
      @(negedge clk);
      if (io_oe_en === 1'b1 && io_at < 0) io_at = e;
      if (core_rst_n === 1'b1 && core_at < 0) core_at = e;
      compared++;
      if (obs !== exp_vec()) begin mismatched++; $display("FAIL por_seq e=%0d got %b want %b", e, obs, exp_vec()); end
    end
    compared++;
    if (io_at != 19) begin mismatched++; $display("FAIL io_rise_edge got %0d want 19", io_at); end
    compared++;
    if (core_at != 51) begin mismatched++; $display("FAIL core_rise_edge got %0d want 51", core_at); end
  endtask
  task automatic test_sw_pulse();
    int first_low, low_cnt;
    first_low = -1; low_cnt = 0;
    repeat ($urandom_range(5, 0)) @(negedge clk);
    sw_rst_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sw_rst_req = 1'b0;
      if (core_rst_n === 1'b0) begin low_cnt++; if (first_low < 0) first_low = i; end
      compared++;
      if (obs !== exp_vec()) begin mismatched++; $display("FAIL sw_pulse i=%0d got %b want %b", i, obs, exp_vec()); end
    end
    compared++;
    if (first_low != 1) begin mismatched++; $display("FAIL sw_latency got %0d want 1", first_low); end
    compared++;
    if (low_cnt != SWL) begin mismatched++; $display("FAIL sw_low_len got %0d want %0d", low_cnt, SWL); end
    compared++;
    if (rst_cause !== 2'b10) begin mismatched++; $display("FAIL sw_cause got %b want 10", rst_cause); end
  endtask
  task automatic test_sw_hold();
    int falls;
    logic prev;
    falls = 0; prev = core_rst_n;
    sw_rst_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 39) sw_rst_req = 1'b0;
      if (prev === 1'b1 && core_rst_n === 1'b0) falls++;
      prev = core_rst_n;
      compared++;
      if (obs !== exp_vec()) begin mismatched++; $display("FAIL sw_hold i=%0d got %b want %b", i, obs, exp_vec()); end
    end
    compared++;
    if (falls != 1) begin mismatched++; $display("FAIL sw_hold_falls got %0d want 1", falls); end
  endtask
  task automatic test_mid_abort();
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      compared++;
      if (obs !== exp_vec()) begin mismatched++; $display("FAIL abort_pre e=%0d got %b want %b", e, obs, exp_vec()); end
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (obs !== 7'b0000001) begin mismatched++; $display("FAIL abort_async got %b want 0000001", obs); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 55; e++) begin
      @(negedge clk);
      compared++;
      if (obs !== exp_vec()) begin mismatched++; $display("FAIL abort_reseq e=%0d got %b want %b", e, obs, exp_vec()); end
    end
    compared++;
    if (rst_cause !== 2'b01 || ready !== 1'b1) begin mismatched++; $display("FAIL abort_final got cause=%b ready=%b want 01/1", rst_cause, ready); end
  endtask
  task automatic test_ignored();
    int p1, low_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p1 = $urandom_range(15, 5);
    for (int e = 1; e <= 55; e++) begin
      @(negedge clk);
      sw_rst_req = (e == p1);
      compared++;
      if (obs !== exp_vec()) begin mismatched++; $display("FAIL ign_io e=%0d got %b want %b", e, obs, exp_vec()); end
    end
    sw_rst_req = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sw_rst_req = (i == 3 || i == 6);
      if (core_rst_n === 1'b0) low_cnt++;
      compared++;
      if (obs !== exp_vec()) begin mismatched++; $display("FAIL ign_sw i=%0d got %b want %b", i, obs, exp_vec()); end
    end
    compared++;
    if (low_cnt != SWL) begin mismatched++; $display("FAIL ign_sw_len got %0d want %0d", low_cnt, SWL); end
  endtask
  task automatic test_glitch();
    sw_rst_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    compared++;
    if (obs !== 7'b0000001) begin mismatched++; $display("FAIL glitch_clear got %b want 0000001", obs); end
    #2 rst_n = 1'b1;
    #1;
    compared++;
    if (obs !== 7'b0000001) begin mismatched++; $display("FAIL glitch_release got %b want 0000001", obs); end
    for (int e = 1; e <= 55; e++) begin
      @(negedge clk);
      compared++;
      if (obs !== exp_vec()) begin mismatched++; $display("FAIL glitch_reseq e=%0d got %b want %b", e, obs, exp_vec()); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      compared++;
      if (obs !== exp_vec()) begin mismatched++; $display("FAIL random i=%0d got %b want %b", i, obs, exp_vec()); end
      if ($urandom_range(5, 0) == 0) sw_rst_req = ~sw_rst_req;
    end
    sw_rst_req = 1'b0;
  endtask
  initial begin
    test_reset();
    test_sw_pulse();
    test_sw_hold();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_mid_abort();
    test_ignored();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
